// File: rtl/srl_delay_ctrl.sv
// Programmable shift-register delay line: tap select, fill tracking, output-valid qualification.
// Latency: len_cur ce-qualified edges (len_cur+1 with SRL_DELAY_OREG_EN defined, registered q/q_valid).
// Backpressure: none; ce=0 freezes chain, fill count and q. Optional macro: SRL_DELAY_OREG_EN.
module srl_delay_ctrl #(
    parameter int width    = 1,
    parameter int depth    = 130,
    parameter int INIT_LEN = 130,
    parameter int LW       = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             ce,
    input  logic [width-1:0] i,
    input  logic             len_wr,
    input  logic [LW-1:0]    len_req,
    output logic [width-1:0] q,
    output logic             q_valid,
    output logic [LW-1:0]    len_cur,
    output logic             busy,
    output logic             cfg_err
);

    localparam int IW = (depth > 1) ? $clog2(depth) : 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [LW-1:0]     fill_cnt, fill_nxt, len_nxt;
    logic              cfg_err_nxt;
    logic              len_ok;
    logic              valid_c;
    logic [IW-1:0]     tap;
    logic [width-1:0]  stage [depth];

    assign len_ok = (len_req != '0) && (len_req <= LW'(depth));
    assign tap    = IW'(len_cur - LW'(1));

    // Data flops stay reset-free so the chain can map onto SRL primitives.
    always_ff @(posedge clk) begin
        if (ce) begin
            stage[0] <= i;
            for (int k = 1; k < depth; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        fill_nxt    = fill_cnt;
        len_nxt     = len_cur;
        cfg_err_nxt = cfg_err;
        busy        = (state == FILL);
        valid_c     = (state == RUN);
        if (len_wr && len_ok) begin
            // The write edge itself never counts toward the fill.
            state_nxt = FILL;
            fill_nxt  = len_req;
            len_nxt   = len_req;
        end else begin
            if (len_wr) begin
                cfg_err_nxt = 1'b1;
            end
            if (state == FILL && ce) begin
                if (fill_cnt == LW'(1)) begin
                    state_nxt = RUN;
                end
                fill_nxt = fill_cnt - LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r) begin
            state    <= FILL;
            fill_cnt <= LW'(INIT_LEN);
            len_cur  <= LW'(INIT_LEN);
            cfg_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fill_cnt <= fill_nxt;
            len_cur  <= len_nxt;
            cfg_err  <= cfg_err_nxt;
        end
    end

`ifdef SRL_DELAY_OREG_EN
    logic [width-1:0] q_r;
    logic             q_valid_r;

    always_ff @(posedge clk) begin
        if (ce) begin
            q_r <= stage[tap];
        end
    end

    always_ff @(posedge clk) begin
        if (r || (len_wr && len_ok)) begin
            q_valid_r <= 1'b0;
        end else if (ce) begin
            q_valid_r <= valid_c;
        end
    end

    assign q       = q_r;
    assign q_valid = q_valid_r;
`else
    assign q       = stage[tap];
    assign q_valid = valid_c;
`endif

endmodule

// File: tb/tb_srl_delay_ctrl.sv
// Bench for srl_delay_ctrl: directed table, scenario sequences and randomized traffic vs a history-queue model.
module tb_srl_delay_ctrl;

    localparam int W    = 8;
    localparam int D    = 16;
    localparam int INIT = 16;
    localparam int LWT  = $clog2(D + 1);
`ifdef SRL_DELAY_OREG_EN
    localparam int OL = 1;
`else
    localparam int OL = 0;
`endif

    logic           clk = 1'b0;
    logic           r = 1'b0;
    logic           ce = 1'b0;
    logic [W-1:0]   i = '0;
    logic           len_wr = 1'b0;
    logic [LWT-1:0] len_req = '0;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [LWT-1:0] len_cur;
    logic           busy;
    logic           cfg_err;

    srl_delay_ctrl #(.width(W), .depth(D), .INIT_LEN(INIT)) dut (
        .clk(clk), .r(r), .ce(ce), .i(i), .len_wr(len_wr), .len_req(len_req),
        .q(q), .q_valid(q_valid), .len_cur(len_cur), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: the delay line is just "the last N accepted samples"; the output is
    // valid once at least len (+1 when registered) ce edges followed the last config.
    logic [W-1:0] hist[$];
    int           len_m   = INIT;
    int           since_m = 0;
    bit           err_m   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rr, input bit cc, input logic [W-1:0] ii,
                        input bit ww, input logic [LWT-1:0] lq);
        bit exp_valid;
        r = rr; ce = cc; i = ii; len_wr = ww; len_req = lq;
        @(posedge clk);
        if (cc) begin
            hist.push_front(ii);
            if (hist.size() > 40) void'(hist.pop_back());
        end
        if (rr) begin
            len_m = INIT; since_m = 0; err_m = 1'b0;
        end else if (ww && lq >= 1 && lq <= D) begin
            len_m = lq; since_m = 0;
        end else begin
            if (ww) err_m = 1'b1;
            if (cc && since_m < 1000) since_m++;
        end
        #1;
        exp_valid = (since_m >= len_m + OL);
        check("len_cur", 32'(len_cur), 32'(len_m));
        check("busy", 32'(busy), 32'(since_m < len_m));
        check("q_valid", 32'(q_valid), 32'(exp_valid));
        check("cfg_err", 32'(cfg_err), 32'(err_m));
        if (exp_valid && hist.size() > len_m - 1 + OL)
            check("q", 32'(q), 32'(hist[len_m - 1 + OL]));
    endtask

    typedef struct {
        bit             r;
        bit             ce;
        bit             wr;
        logic [LWT-1:0] req;
        bit             e_busy;
        bit             e_valid;
        logic [LWT-1:0] e_len;
        bit             e_err;
    } vec_t;

    vec_t tbl[15];

    initial begin
        //           r  ce wr req busy valid len err
        tbl[0]  = '{1, 0, 0, 0,  1, 0, 16, 0};
        tbl[1]  = '{0, 1, 1, 0,  1, 0, 16, 1};
        tbl[2]  = '{0, 1, 1, 3,  1, 0, 3,  1};
        tbl[3]  = '{0, 1, 0, 0,  1, 0, 3,  1};
        tbl[4]  = '{0, 0, 0, 0,  1, 0, 3,  1};
        tbl[5]  = '{0, 1, 0, 0,  1, 0, 3,  1};
        tbl[6]  = '{0, 1, 0, 0,  0, 1, 3,  1};
        tbl[7]  = '{0, 1, 1, 17, 0, 1, 3,  1};
        tbl[8]  = '{1, 1, 1, 5,  1, 0, 16, 0};
        tbl[9]  = '{0, 0, 1, 16, 1, 0, 16, 0};
        tbl[10] = '{0, 1, 1, 1,  1, 0, 1,  0};
        tbl[11] = '{0, 1, 0, 0,  0, 1, 1,  0};
        tbl[12] = '{0, 0, 0, 0,  0, 1, 1,  0};
        tbl[13] = '{0, 0, 1, 1,  1, 0, 1,  0};
        tbl[14] = '{0, 1, 0, 0,  0, 1, 1,  0};

        // Reset then fill from INIT_LEN with an incrementing stream.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 22; k++) step(0, 1, W'(k), 0, 0);

        // Shorten to 4 while streaming, then keep streaming.
        step(0, 1, 8'h40, 1, 4);
        for (int k = 0; k < 10; k++) step(0, 1, W'(8'h41 + k), 0, 0);

        // Refill with ce toggling; q must hold on ce=0 once valid.
        step(0, 1, 8'h60, 1, 4);
        for (int k = 0; k < 14; k++) step(0, k % 2 == 0, W'(8'h61 + k), 0, 0);

        // Illegal writes in RUN at full length, then reset clears the flag.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 18; k++) step(0, 1, W'(8'h80 + k), 0, 0);
        step(0, 1, 8'h92, 1, 0);
        step(0, 1, 8'h93, 0, 0);
        step(0, 1, 8'h94, 1, 17);
        step(0, 0, 8'h95, 1, 31);
        step(0, 1, 8'h96, 0, 0);
        step(1, 0, 8'h97, 0, 0);

        // Directed table: mid-fill restart, reset beating a write, equal-length restart.
        for (int n = 0; n < 15; n++) begin
            step(tbl[n].r, tbl[n].ce, W'(8'hA0 + n), tbl[n].wr, tbl[n].req);
            check("tbl_busy", 32'(busy), 32'(tbl[n].e_busy));
            check("tbl_len", 32'(len_cur), 32'(tbl[n].e_len));
            check("tbl_err", 32'(cfg_err), 32'(tbl[n].e_err));
`ifndef SRL_DELAY_OREG_EN
            check("tbl_valid", 32'(q_valid), 32'(tbl[n].e_valid));
`endif
        end

        // Randomized traffic.
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 W'($urandom),
                 $urandom_range(0, 24) == 0,
                 LWT'($urandom_range(0, 18)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/srl_delay_ctrl.md
Name: srl_delay_ctrl

Overview:
Controller for a runtime-variable-length shift-register delay line (tap select over a chain of data flops). It owns the tap length, the fill/priming state and the output-valid qualification. Control state uses synchronous reset. Data flops carry no reset and no init value, so synthesis can still map the chain to SRL primitives. Sits between a streaming producer and any consumer needing a programmable delay, such as alignment or pipeline balancing.

Parameters:
width, 1, data bits per stage
depth, 130, maximum delay in stages (physical chain length)
INIT_LEN, 130, tap length after reset; legal range 1..depth
LW, $clog2(depth+1), width of length fields

Ports:
clk  input  1  rising-edge clock
r  input  1  reset; synchronous, active-high
ce  input  1  shift enable; chain and fill counter advance only when high
i  input  width  data in; sampled on clk edges where ce=1
len_wr  input  1  length-write strobe, single cycle
len_req  input  LW  requested tap length, valid when len_wr=1
q  output  width  delayed data = chain stage len_cur-1 (stage 0 loads i)
q_valid  output  1  q holds a sample presented after the last (re)configuration
len_cur  output  LW  active tap length
busy  output  1  high while in FILL
cfg_err  output  1  sticky illegal-length flag

Behaviour:
- Clock and reset: one clock, clk. Reset r is synchronous and active-high.
- Reset (r=1 at an edge):
  - state=FILL, len_cur=INIT_LEN, fill_cnt=INIT_LEN.
  - q_valid=0, busy=1, cfg_err=0.
  - Chain contents are untouched; q is undefined until q_valid=1.
  - r has priority over len_wr and ce control effects. The chain itself may still shift.
- Data path:
  - On each edge with ce=1: stage[0]<=i and stage[k]<=stage[k-1].
  - q is combinational from stage[len_cur-1], so latency = len_cur ce-qualified edges.
  - ce=0 freezes the chain, q and fill_cnt.
- FSM, two states:
  - FILL: busy=1, q_valid=0. Each ce edge decrements fill_cnt. A ce edge with fill_cnt==1 moves to RUN; q_valid=1 from the next cycle.
  - RUN: busy=0, q_valid=1. Stays until a legal len_wr or r.
- Length write (len_wr=1, any state):
  - Legal (1<=len_req<=depth): at the edge, len_cur<=len_req, fill_cnt<=len_req, state<=FILL. q_valid is 0 from the next cycle.
  - A ce on the write edge still shifts data but does not decrement fill_cnt. q_valid therefore rises after exactly len_req further ce edges.
  - A write during FILL restarts the count.
  - A write equal to len_cur is still a restart.
  - Illegal (0 or >depth): ignored. len_cur, state and q_valid are unchanged; cfg_err<=1, held until r.
- Width rules:
  - len_req compare is unsigned, full LW bits.
  - fill_cnt is LW bits and never underflows (cannot be 0 in FILL).
  - Tap index = len_cur-1, always in 0..depth-1.

Optional Feature:
SRL_DELAY_OREG_EN:
- Defined: q and q_valid are registered.
  - Output register loads on edges with ce=1; q_valid reg also clears on r or a legal len_wr.
  - Total latency = len_cur+1 ce edges; q_valid rises one ce edge later than without the macro.
  - busy timing is unchanged.
- Undefined: q and q_valid come combinationally from the tap and the FSM, as above.

Test Plan (width=8, depth=16, INIT_LEN=16, macro off unless stated):
1. r=1 for 2 cycles, then ce=1 with i=0,1,2,… one per cycle -> busy=1 and q_valid=0 for 16 edges; first q_valid=1 cycle shows q=0, then q increments each cycle.
2. In RUN, len_wr with len_req=4 while streaming -> q_valid=0 next cycle for 4 ce edges; then q_valid=1 and q=i from 4 edges earlier; len_cur=4.
3. In FILL with len 4, ce pattern 1,0,1,0,… -> q_valid rises only after the 4th ce=1 edge; q holds steady on ce=0 cycles.
4. len_wr with len_req=0, then with 17, in RUN -> cfg_err=1 sticky, len_cur stays 16, q_valid stays 1, no FILL; next r clears cfg_err.
5. Mid-FILL len_wr len_req=3 -> count restarts, valid after 3 ce edges. Then r and len_wr(len_req=5) in the same cycle -> len_cur=16, fill restarts with 16.
6. SRL_DELAY_OREG_EN defined, repeat scenario 2 -> q_valid rises after 5 ce edges; q equals i from 5 edges earlier.
